register_bus_sequencer: RTL and testbench

REGISTER_BUS_SEQUENCER -- requirements
Module: register_bus_sequencer

---
 rtl/register_bus_pkg.sv | 13 +
 rtl/rr_arbiter_2.sv | 31 +++
 rtl/register_bus_sequencer.sv | 123 ++++++++++++
 tb/tb_register_bus_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bus_pkg.sv
// rtl/register_bus_pkg.sv - shared types and constants for the register bus sequencer
package register_bus_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter
// The pointer names the favoured requester; it moves past a winner only when the grant is taken.
module rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

  // A win by requester i hands priority to 1-i, which is exactly grant[0].
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/register_bus_sequencer.sv
// rtl/register_bus_sequencer.sv - moves one register value to another over a shared bus
// Each move is IDLE -> READ -> CAPTURE -> WRITE, two requesters arbitrated round-robin.
module register_bus_sequencer
  import register_bus_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_REGS  = 4,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]      req_src,
  input  logic [NUM_REQ*IDX_W-1:0]      req_dst,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic [NUM_REGS-1:0]           reg_enable,
  output logic [NUM_REGS-1:0]           reg_read,
  output logic [NUM_REGS-1:0]           reg_write,
  input  logic [NUM_REGS*WORD_SIZE-1:0] reg_data_in,
  output logic [WORD_SIZE-1:0]          bus_value
);

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     src_q;
  logic [IDX_W-1:0]     dst_q;
  logic                 id_q;
  logic [WORD_SIZE-1:0] bus_q;

  logic [NUM_REQ-1:0]   grant;
  logic                 grant_id;
  logic [IDX_W-1:0]     grant_src;
  logic [IDX_W-1:0]     grant_dst;
  logic                 accept;

  rr_arbiter_2 u_arbiter (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign grant_id  = grant[1];
  assign grant_src = req_src[int'(grant_id)*IDX_W +: IDX_W];
  assign grant_dst = req_dst[int'(grant_id)*IDX_W +: IDX_W];
  assign accept    = (state == ST_IDLE) && (grant != '0) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      id_q  <= 1'b0;
    end else if (accept) begin
      src_q <= grant_src;
      dst_q <= grant_dst;
      id_q  <= grant_id;
    end
  end

  // The latch holds the moved word from CAPTURE through WRITE and beyond.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_q <= '0;
    end else if (state == ST_CAPTURE) begin
      bus_q <= reg_data_in[int'(src_q)*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (accept) state_next = ST_READ;
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_WRITE;
      ST_WRITE:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is high so an abandoned move emits nothing.
  always_comb begin
    req_ready  = '0;
    done       = '0;
    reg_enable = '0;
    reg_read   = '0;
    reg_write  = '0;
    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          req_ready = grant;
        end
        ST_READ: begin
          reg_enable[src_q] = 1'b1;
          reg_read[src_q]   = 1'b1;
        end
        ST_CAPTURE: begin
        end
        ST_WRITE: begin
          reg_enable[dst_q] = 1'b1;
          reg_write[dst_q]  = 1'b1;
          done[id_q]        = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE) && !reset;
  assign bus_value = reset ? '0 : bus_q;

endmodule

// File: tb/tb_register_bus_sequencer.sv
// tb/tb_register_bus_sequencer.sv - self-checking bench for register_bus_sequencer
module tb_register_bus_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [3:0] req_src = '0;
  logic [3:0] req_dst = '0;
  logic [1:0] req_ready;
  logic [1:0] done;
  logic       busy;
  logic [3:0] reg_enable;
  logic [3:0] reg_read;
  logic [3:0] reg_write;
  logic [31:0] reg_data_in;
  logic [7:0] bus_value;

  logic [7:0] regs [4];
  logic       pre_en = 1'b0;
  logic [1:0] pre_idx = '0;
  logic [7:0] pre_val = '0;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  register_bus_sequencer #(.WORD_SIZE(8), .NUM_REGS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_src     (req_src),
    .req_dst     (req_dst),
    .req_ready   (req_ready),
    .done        (done),
    .busy        (busy),
    .reg_enable  (reg_enable),
    .reg_read    (reg_read),
    .reg_write   (reg_write),
    .reg_data_in (reg_data_in),
    .bus_value   (bus_value)
  );

  // Register file on the bus, with a back door for preloading.
  always @(posedge clock) begin
    if (pre_en) begin
      regs[pre_idx] <= pre_val;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (reg_enable[k] && reg_write[k]) regs[k] <= bus_value;
      end
    end
  end

  always_comb begin
    reg_data_in = '0;
    for (int k = 0; k < 4; k++) reg_data_in[k*8 +: 8] = regs[k];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input int idx, input logic [7:0] val);
    pre_en  = 1'b1;
    pre_idx = 2'(idx);
    pre_val = val;
    tick();
    pre_en = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] valid;
    logic [3:0] src;
    logic [3:0] dst;
    logic [1:0] ready;
    logic [3:0] en;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [1:0] dn;
    logic       bsy;
    logic [7:0] bus;
  } vec_t;

  typedef struct {
    int         id;
    int         dst;
    logic [7:0] val;
  } sb_t;

  vec_t       tbl [10];
  sb_t        sbq [$];
  sb_t        item;
  logic [7:0] shadow [4];
  logic [1:0] pend;
  int         s [2];
  int         d [2];

  initial begin
    // Move 2->1 then 0->0, one row per cycle.
    tbl[0] = '{1'b1, 2'b01, 4'h2, 4'h1, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 2'b01, 4'h2, 4'h1, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h4, 4'h4, 4'h0, 2'b00, 1'b1, 8'h00};
    tbl[3] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 8'h00};
    tbl[4] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h2, 4'h0, 4'h2, 2'b01, 1'b1, 8'h5A};
    tbl[5] = '{1'b0, 2'b01, 4'h0, 4'h0, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 8'h5A};
    tbl[6] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h1, 4'h1, 4'h0, 2'b00, 1'b1, 8'h5A};
    tbl[7] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 8'h5A};
    tbl[8] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h1, 4'h0, 4'h1, 2'b01, 1'b1, 8'hA5};
    tbl[9] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 8'hA5};

    reset = 1'b1;
    tick();
    preload(0, 8'hA5);
    preload(1, 8'h11);
    preload(2, 8'h5A);
    preload(3, 8'h33);

    for (int i = 0; i < 10; i++) begin
      reset     = tbl[i].rst;
      req_valid = tbl[i].valid;
      req_src   = tbl[i].src;
      req_dst   = tbl[i].dst;
      #1;
      check($sformatf("row%0d", i),
            {7'd0, req_ready, reg_enable, reg_read, reg_write, done, busy, bus_value},
            {7'd0, tbl[i].ready, tbl[i].en, tbl[i].rd, tbl[i].wr, tbl[i].dn, tbl[i].bsy, tbl[i].bus});
      tick();
    end
    check("reg1_after_move", 32'(regs[1]), 32'h5A);
    check("reg0_self_move", 32'(regs[0]), 32'hA5);

    // Both requesters held valid from reset: grants alternate every 4 cycles.
    reset = 1'b1;
    req_valid = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    req_valid = 2'b11;
    req_src = {2'd3, 2'd1};
    req_dst = {2'd0, 2'd2};
    for (int c = 0; c < 16; c++) begin
      #1;
      check($sformatf("rr_c%0d", c), 32'(req_ready),
            (c % 4 != 0) ? 32'd0 : (((c / 4) % 2 == 0) ? 32'd1 : 32'd2));
      tick();
    end
    req_valid = 2'b00;

    // Reset in CAPTURE of move 0->3 abandons it.
    reset = 1'b1;
    preload(0, 8'h77);
    preload(3, 8'h3C);
    reset = 1'b0;
    req_valid = 2'b01;
    req_src = 4'h0;
    req_dst = 4'h3;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    #1;
    check("abort_read", 32'(reg_read), 32'h1);
    tick();
    reset = 1'b1;
    #1;
    check("abort_in_reset", {15'd0, reg_enable, reg_read, reg_write, done, busy}, 32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("abort_after%0d", c), {25'd0, reg_write, done, busy}, 32'd0);
      tick();
    end
    check("abort_reg3", 32'(regs[3]), 32'h3C);

    // Random traffic with scoreboard and protocol checks.
    reset = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      shadow[k] = 8'($urandom_range(0, 255));
      preload(k, shadow[k]);
    end
    reset = 1'b0;
    pend = 2'b00;
    s[0] = 0; s[1] = 0; d[0] = 0; d[1] = 0;
    for (int cyc = 0; cyc < 1010; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && cyc < 1000 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          s[i] = int'($urandom_range(0, 3));
          d[i] = int'($urandom_range(0, 3));
        end
      end
      req_valid = pend;
      req_src = {2'(s[1]), 2'(s[0])};
      req_dst = {2'(d[1]), 2'(d[0])};
      #1;
      check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      check("en_onehot", 32'($onehot0(reg_enable)), 32'd1);
      check("rd_onehot", 32'($onehot0(reg_read)), 32'd1);
      check("wr_onehot", 32'($onehot0(reg_write)), 32'd1);
      check("rd_wr_excl", 32'(reg_read & reg_write), 32'd0);
      if (req_ready != 2'b00) check("ready_when_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          sbq.push_back('{i, d[i], shadow[s[i]]});
          shadow[d[i]] = shadow[s[i]];
          pend[i] = 1'b0;
        end
      end
      if (done != 2'b00) begin
        if (sbq.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          item = sbq.pop_front();
          check("done_id", 32'(done), 32'(1) << item.id);
          check("write_dst", 32'(reg_write), 32'(1) << item.dst);
          check("bus_val", 32'(bus_value), 32'(item.val));
        end
      end
      tick();
    end
    req_valid = 2'b00;
    check("sb_empty", 32'(sbq.size()), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("final_reg%0d", k), 32'(regs[k]), 32'(shadow[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
